// File: rtl/alarm_sequencer.sv
// Alarm-clock control FSM: fires the song player on the rising edge of an hour:minute match
// and sequences ringing, snooze and stop. Optional ring timeout: define ALARM_RING_TIMEOUT_EN.
module alarm_sequencer #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       resetA,
    input  logic       sec_tick,
    input  logic       arm_sw,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [4:0] alm_hr,
    input  logic [5:0] alm_min,
    output logic       play,
    output logic       flash,
    output logic       snoozing,
    output logic [2:0] snooze_left,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_RINGING = 2'd2;
    localparam logic [1:0] S_SNOOZE  = 2'd3;

    localparam int             TMR_W    = $clog2(SNOOZE_SEC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SNOOZE_SEC);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [2:0]     SNZ_MAX  = 3'(MAX_SNOOZE);

    logic [1:0]       r_state;
    logic             r_match_q;
    logic [TMR_W-1:0] r_snz_tmr;
    logic [2:0]       r_snz_used;
    logic             r_flash;
    logic             r_play;
    logic             r_snoozing;
    logic [2:0]       r_snooze_left;

    logic [1:0]       w_state_nx;
    logic [TMR_W-1:0] w_tmr_nx;
    logic [2:0]       w_used_nx;
    logic             w_flash_nx;
    logic             w_match;
    logic             w_fire;
    logic             w_timeout;

    // Raw compare: out-of-range alarm settings simply never match.
    assign w_match = (cur_hr == alm_hr) && (cur_min == alm_min);
    assign w_fire  = w_match && !r_match_q;

`ifdef ALARM_RING_TIMEOUT_EN
    localparam int              RC_W    = $clog2(RING_TIMEOUT_SEC + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

    logic [RC_W-1:0] r_ring_cnt;
    logic [RC_W-1:0] w_ring_nx;

    assign w_timeout = sec_tick && (r_ring_cnt == RC_LAST);
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign w_unused  = ^{1'b0, 32'(RING_TIMEOUT_SEC)};
`endif

    always_comb begin
        // NOTE: every next-value signal gets a default first so no path can infer a latch.
        w_state_nx = r_state;
        w_tmr_nx   = r_snz_tmr;
        w_used_nx  = r_snz_used;
        w_flash_nx = 1'b0;
`ifdef ALARM_RING_TIMEOUT_EN
        w_ring_nx  = r_ring_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (arm_sw) w_state_nx = S_ARMED;
            end
            S_ARMED: begin
                if (!arm_sw) begin
                    w_state_nx = S_IDLE;
                end else if (w_fire) begin
                    w_state_nx = S_RINGING;
                    w_used_nx  = 3'd0;
`ifdef ALARM_RING_TIMEOUT_EN
                    w_ring_nx  = '0;
`endif
                end
            end
            S_RINGING: begin
                if (!arm_sw) begin
                    w_state_nx = S_IDLE;
                end else if (stop_btn) begin
                    w_state_nx = S_ARMED;
                end else if (snooze_btn && (r_snz_used < SNZ_MAX)) begin
                    w_state_nx = S_SNOOZE;
                    w_used_nx  = r_snz_used + 3'd1;
                    w_tmr_nx   = TMR_LOAD;
                end else if (w_timeout) begin
                    w_state_nx = S_ARMED;
                end else if (sec_tick) begin
                    w_flash_nx = !r_flash;
`ifdef ALARM_RING_TIMEOUT_EN
                    w_ring_nx  = r_ring_cnt + RC_ONE;
`endif
                end else begin
                    w_flash_nx = r_flash;
                end
            end
            default: begin
                if (!arm_sw) begin
                    w_state_nx = S_IDLE;
                end else if (stop_btn) begin
                    w_state_nx = S_ARMED;
                end else if (sec_tick) begin
                    if (r_snz_tmr == TMR_ONE) begin
                        w_state_nx = S_RINGING;
`ifdef ALARM_RING_TIMEOUT_EN
                        w_ring_nx  = '0;
`endif
                    end else begin
                        w_tmr_nx = r_snz_tmr - TMR_ONE;
                    end
                end
            end
        endcase
        // Outside an alarm event the snooze budget is always full.
        if ((w_state_nx == S_IDLE) || (w_state_nx == S_ARMED)) w_used_nx = 3'd0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!resetA) begin
            r_state       <= S_IDLE;
            r_match_q     <= 1'b0;
            r_snz_tmr     <= '0;
            r_snz_used    <= 3'd0;
            r_flash       <= 1'b0;
            r_play        <= 1'b0;
            r_snoozing    <= 1'b0;
            r_snooze_left <= SNZ_MAX;
`ifdef ALARM_RING_TIMEOUT_EN
            r_ring_cnt    <= '0;
`endif
        end else begin
            r_state       <= w_state_nx;
            r_match_q     <= w_match;
            r_snz_tmr     <= w_tmr_nx;
            r_snz_used    <= w_used_nx;
            r_flash       <= w_flash_nx;
            r_play        <= (w_state_nx == S_RINGING);
            r_snoozing    <= (w_state_nx == S_SNOOZE);
            r_snooze_left <= SNZ_MAX - w_used_nx;
`ifdef ALARM_RING_TIMEOUT_EN
            r_ring_cnt    <= w_ring_nx;
`endif
        end
    end

    assign state       = r_state;
    assign play        = r_play;
    assign flash       = r_flash;
    assign snoozing    = r_snoozing;
    assign snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios plus random traffic, compared
// every cycle against a behavioural alarm model. Honours ALARM_RING_TIMEOUT_EN if defined.
module tb_alarm_sequencer;

    localparam int SNOOZE_SEC       = 3;
    localparam int RING_TIMEOUT_SEC = 5;
    localparam int MAX_SNOOZE       = 2;

    logic       clk = 1'b0;
    logic       resetA = 1'b0;
    logic       sec_tick = 1'b0;
    logic       arm_sw = 1'b0;
    logic       stop_btn = 1'b0;
    logic       snooze_btn = 1'b0;
    logic [4:0] cur_hr = 5'd7;
    logic [5:0] cur_min = 6'd29;
    logic [4:0] alm_hr = 5'd7;
    logic [5:0] alm_min = 6'd30;
    logic       play;
    logic       flash;
    logic       snoozing;
    logic [2:0] snooze_left;
    logic [1:0] state;

    alarm_sequencer #(
        .SNOOZE_SEC      (SNOOZE_SEC),
        .RING_TIMEOUT_SEC(RING_TIMEOUT_SEC),
        .MAX_SNOOZE      (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .resetA     (resetA),
        .sec_tick   (sec_tick),
        .arm_sw     (arm_sw),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .cur_hr     (cur_hr),
        .cur_min    (cur_min),
        .alm_hr     (alm_hr),
        .alm_min    (alm_min),
        .play       (play),
        .flash      (flash),
        .snoozing   (snoozing),
        .snooze_left(snooze_left),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the alarm's situation in plain terms.
    typedef enum int { M_IDLE = 0, M_ARMED = 1, M_RINGING = 2, M_SNOOZE = 3 } mode_t;
    mode_t m_mode         = M_IDLE;
    bit    m_was_matching = 1'b0;
    int    m_snoozes      = 0;
    int    m_snooze_ticks = 0;
    int    m_ring_seconds = 0;
    bit    m_flash        = 1'b0;

    task automatic model_step();
        bit matching;
        bit fire;
        if (!resetA) begin
            m_mode = M_IDLE; m_was_matching = 1'b0; m_snoozes = 0;
            m_snooze_ticks = 0; m_ring_seconds = 0; m_flash = 1'b0;
            return;
        end
        matching = (cur_hr == alm_hr) && (cur_min == alm_min);
        fire = matching && !m_was_matching;
        m_was_matching = matching;
        case (m_mode)
            M_IDLE: if (arm_sw) m_mode = M_ARMED;
            M_ARMED: begin
                if (!arm_sw) m_mode = M_IDLE;
                else if (fire) begin
                    m_mode = M_RINGING; m_snoozes = 0; m_ring_seconds = 0; m_flash = 1'b0;
                end
            end
            M_RINGING: begin
                if (!arm_sw) m_mode = M_IDLE;
                else if (stop_btn) m_mode = M_ARMED;
                else if (snooze_btn && m_snoozes < MAX_SNOOZE) begin
                    m_snoozes++;
                    m_snooze_ticks = SNOOZE_SEC;
                    m_mode = M_SNOOZE;
                end else if (sec_tick) begin
                    m_ring_seconds++;
`ifdef ALARM_RING_TIMEOUT_EN
                    if (m_ring_seconds >= RING_TIMEOUT_SEC) m_mode = M_ARMED;
                    else m_flash = !m_flash;
`else
                    m_flash = !m_flash;
`endif
                end
            end
            M_SNOOZE: begin
                if (!arm_sw) m_mode = M_IDLE;
                else if (stop_btn) m_mode = M_ARMED;
                else if (sec_tick) begin
                    m_snooze_ticks--;
                    if (m_snooze_ticks == 0) begin
                        m_mode = M_RINGING; m_ring_seconds = 0;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
        if (m_mode != M_RINGING) m_flash = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_ARMED) m_snoozes = 0;
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",       int'(state),       int'(m_mode));
            check("play",        int'(play),        int'(m_mode == M_RINGING));
            check("snoozing",    int'(snoozing),    int'(m_mode == M_SNOOZE));
            check("flash",       int'(flash),       int'(m_flash));
            check("snooze_left", int'(snooze_left), MAX_SNOOZE - m_snoozes);
        end
    end

    // One clock: model samples the same inputs the DUT samples, then inputs advance.
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        sec_tick   = (cyc % 10 == 0);
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    // Runs until n sec_ticks have been sampled; bounded.
    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < 20 * n + 20 && seen < n; c++) begin
            if (sec_tick) seen++;
            tick_cycle();
        end
        check("tick_budget", seen, n);
    endtask

    task automatic fire_alarm();
        cur_min = 6'd31;
        run(2);
        cur_min = 6'd30;
        tick_cycle();
    endtask

    initial begin
        // Reset
        run(1);
        cmp_en = 1'b1;
        run(2);
        check("rst_state", int'(state), 0);
        check("rst_play", int'(play), 0);
        check("rst_snooze_left", int'(snooze_left), MAX_SNOOZE);
        resetA = 1'b1;

        // Basic fire at 07:30
        arm_sw = 1'b1;
        run(2);
        check("armed_state", int'(state), 1);
        cur_min = 6'd30;
        tick_cycle();
        check("fire_play", int'(play), 1);
        check("fire_state", int'(state), 2);
        check("fire_flash_start", int'(flash), 0);
        run(25);
        stop_btn = 1'b1;
        tick_cycle();
        check("stop_play", int'(play), 0);
        check("stop_state", int'(state), 1);

        // Edge-only: no re-fire while the minute still matches, including re-arming
        run(30);
        check("no_refire_state", int'(state), 1);
        arm_sw = 1'b0;
        run(3);
        check("disarm_state", int'(state), 0);
        arm_sw = 1'b1;
        run(5);
        check("arm_in_match_state", int'(state), 1);
        fire_alarm();
        check("next_day_fire", int'(state), 2);
        stop_btn = 1'b1;
        tick_cycle();

        // Snooze limit
        fire_alarm();
        run(2);
        snooze_btn = 1'b1;
        tick_cycle();
        check("snz1_snoozing", int'(snoozing), 1);
        check("snz1_left", int'(snooze_left), 1);
        wait_ticks(SNOOZE_SEC - 1);
        check("snz1_still", int'(state), 3);
        wait_ticks(1);
        check("snz1_resume", int'(state), 2);
        run(1);
        snooze_btn = 1'b1;
        tick_cycle();
        check("snz2_left", int'(snooze_left), 0);
        wait_ticks(SNOOZE_SEC);
        check("snz2_resume", int'(state), 2);
        run(1);
        snooze_btn = 1'b1;
        tick_cycle();
        check("snz3_ignored_play", int'(play), 1);
        check("snz3_ignored_left", int'(snooze_left), 0);
        stop_btn = 1'b1;
        tick_cycle();

        // Timeout
        fire_alarm();
`ifdef ALARM_RING_TIMEOUT_EN
        wait_ticks(RING_TIMEOUT_SEC - 1);
        check("pre_timeout_state", int'(state), 2);
        wait_ticks(1);
        check("timeout_state", int'(state), 1);
        check("timeout_play", int'(play), 0);
`else
        wait_ticks(21);
        check("no_timeout_state", int'(state), 2);
        check("no_timeout_play", int'(play), 1);
        stop_btn = 1'b1;
        tick_cycle();
`endif

        // Priority: stop beats snooze
        fire_alarm();
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        tick_cycle();
        check("stop_snz_state", int'(state), 1);
        check("stop_snz_left", int'(snooze_left), MAX_SNOOZE);

        // Disarm during snooze
        fire_alarm();
        snooze_btn = 1'b1;
        tick_cycle();
        arm_sw = 1'b0;
        tick_cycle();
        check("disarm_snooze", int'(state), 0);

        // Reset during ringing
        arm_sw = 1'b1;
        tick_cycle();
        fire_alarm();
        resetA = 1'b0;
        tick_cycle();
        check("midrst_state", int'(state), 0);
        check("midrst_play", int'(play), 0);
        check("midrst_flash", int'(flash), 0);
        check("midrst_snoozing", int'(snoozing), 0);
        check("midrst_left", int'(snooze_left), MAX_SNOOZE);
        resetA = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) arm_sw = !arm_sw;
            if ($urandom_range(0, 14) == 0) cur_min = 6'($urandom_range(29, 31));
            if ($urandom_range(0, 299) == 0) alm_hr = (alm_hr == 5'd7) ? 5'd25 : 5'd7;
            stop_btn   = ($urandom_range(0, 79) == 0);
            snooze_btn = ($urandom_range(0, 29) == 0);
            resetA     = ($urandom_range(0, 499) != 0);
            tick_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
